spi_switch_arbiter: RTL and testbench
=====================================

SPI_SWITCH_ARBITER -- requirements
Module: spi_switch_arbiter

Interface
REQ-001 Parameter PORTS, default 4, number of SPI master ports; legal range 2..16.
REQ-002 Parameter GAP_CYCLES, default 4, idle clocks inserted between disconnecting one port and connecting another; legal range 1..255.
REQ-003 Parameter CPOL, default 0, idle level driven on sck when no port is connected.
REQ-004 clk  input  1  single system clock; all ports are synchronous to it.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sel_valid  input  1  kernel switch request strobe.
REQ-007 sel_ready  output  1  block can accept a request this cycle.
REQ-008 sel_en  input  1  1 = connect port sel_idx; 0 = disconnect all ports.
REQ-009 sel_idx  input  clog2(PORTS)  requested port index.
REQ-010 sel_err  output  1  sticky flag for a rejected request; cleared by err_clr.
REQ-011 err_clr  input  1  clears sel_err.
REQ-012 active  output  PORTS  one-hot connected port; all zero when none is connected.
REQ-013 mosi, sck, ss_L  output  1 each  shared bus outputs to the slave.
REQ-014 miso  input  1  shared bus input from the slave.
REQ-015 mosi_ports, sck_ports, ss_L_ports  input  PORTS each  per-port master outputs.
REQ-016 miso_ports  output  PORTS  per-port miso returns.

Function
REQ-017 Control FSM states: IDLE, CONN, DRAIN, GAP.
REQ-018 A request is accepted only on a cycle where sel_valid=1 and sel_ready=1.
REQ-019 sel_ready=1 only in IDLE and CONN.
REQ-020 Accepted request with sel_en=1 and sel_idx>=PORTS: set sel_err, keep the current state, change no connection.
REQ-021 Accepted request with sel_en=1 and sel_idx equal to the connected port: no state change and no gap.
REQ-022 Other accepted requests: latch the target (port index, or "none" when sel_en=0).
  - From IDLE with sel_en=1: go to GAP.
  - From IDLE with sel_en=0: stay in IDLE.
  - From CONN: go to DRAIN.
REQ-023 DRAIN: hold the current connection until ss_L_ports[cur]=1 is sampled high, then go to GAP on the next clock. The SPI transfer in progress is never cut.
REQ-024 GAP: drive the bus idle for exactly GAP_CYCLES clocks, then go to CONN with the latched target, or to IDLE if the target is "none".
REQ-025 Bus idle values: ss_L=1, sck=CPOL, mosi=0, active=0.
REQ-026 In CONN, combinationally route the connected port's signals to the bus:
  - mosi=mosi_ports[cur], sck=sck_ports[cur], ss_L=ss_L_ports[cur];
  - miso_ports[cur]=miso.
REQ-027 miso_ports of every unconnected port are 0 in all states.
REQ-028 active is registered and equals one-hot(cur) exactly in CONN; it is asserted on the same clock edge that enters CONN.
REQ-029 Port inputs of unconnected ports have no effect on any output.
REQ-030 Request-to-connect latency from IDLE: acceptance edge + GAP_CYCLES + 1 clocks until active is set.
REQ-031 Simultaneous err_clr and a new error on the same cycle: sel_err ends at 1 (set wins).
REQ-032 sel_valid while sel_ready=0: ignored, with no side effects and no sel_err.

Reset
REQ-033 While rst=1, asynchronously and immediately:
  - state=IDLE, active=0, sel_err=0, gap counter=0;
  - bus outputs at idle values, miso_ports=0, sel_ready=0.
REQ-034 sel_ready rises on the first clock edge after rst falls.
REQ-035 Reset mid-transfer (in CONN or DRAIN): bus forced idle at once; no port is reconnected after release until a new request arrives.

Verification
REQ-036 PORTS=4, GAP_CYCLES=4: from IDLE, request sel_en=1, sel_idx=2 -> active=4'b0100 exactly 5 clocks after acceptance; bus mirrors port 2; miso_ports=4'b0100 when miso=1.
REQ-037 Connected to port 2 with ss_L_ports[2]=0 for 20 clocks; request port 0 at clock 3 -> port 2 remains routed until ss_L_ports[2] goes high, then 4 idle clocks (ss_L=1, sck=CPOL), then active=4'b0001.
REQ-038 Request sel_idx=5 with PORTS=4 -> sel_err=1, connection unchanged; err_clr pulse -> sel_err=0.
REQ-039 Connected to port 1; request port 1 -> no gap and active unchanged. Request sel_en=0 -> DRAIN, then GAP, then IDLE with active=0.
REQ-040 Assert rst asynchronously mid-transfer on port 3 -> ss_L=1, active=0, sel_ready=0 before the next clock edge; after release the block stays in IDLE.
REQ-041 sel_valid pulses during DRAIN and GAP -> ignored, with no state perturbation and no sel_err.

Source files
------------

// File: rtl/spi_switch_arbiter.sv
// spi_switch_arbiter
// Connects one of PORTS SPI master ports to a single shared slave bus.
// A switch never cuts an SPI transfer in progress: the current port is held
// until it releases ss_L, then the bus idles before the next port is connected.
module spi_switch_arbiter #(
    parameter int PORTS      = 4,
    parameter int GAP_CYCLES = 4,
    parameter int CPOL       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    // switch request channel
    input  logic                         sel_valid,
    output logic                         sel_ready,
    input  logic                         sel_en,
    // One bit wider than a port index when PORTS is a power of two, so that
    // an out-of-range request can be expressed and rejected.
    input  logic [$clog2(PORTS+1)-1:0]   sel_idx,
    output logic                         sel_err,
    input  logic                         err_clr,
    output logic [PORTS-1:0]             active,
    // shared slave bus
    output logic                         mosi,
    output logic                         sck,
    output logic                         ss_L,
    input  logic                         miso,
    // per-port master side
    input  logic [PORTS-1:0]             mosi_ports,
    input  logic [PORTS-1:0]             sck_ports,
    input  logic [PORTS-1:0]             ss_L_ports,
    output logic [PORTS-1:0]             miso_ports
);

    localparam int IDX_W  = $clog2(PORTS + 1);
    localparam int PIDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    localparam logic [PORTS-1:0] ONE      = {{(PORTS-1){1'b0}}, 1'b1};
    localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYCLES);
    localparam logic             SCK_IDLE = (CPOL != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONN  = 2'd1,
        S_DRAIN = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t              state;
    logic [PIDX_W-1:0]   cur;        // port currently routed (CONN/DRAIN)
    logic [PIDX_W-1:0]   tgt;        // port to connect after the gap
    logic                tgt_none;   // gap ends in IDLE instead of CONN
    logic [7:0]          gap_cnt;

    logic accept;
    logic bad_idx;
    logic same_port;
    logic route;

    // Request qualification; the handshake uses the registered ready.
    always_comb begin
        accept    = sel_valid && sel_ready;
        bad_idx   = sel_en && (sel_idx >= IDX_W'(PORTS));
        same_port = sel_en && (state == S_CONN) && (sel_idx == IDX_W'(cur));
    end

    // Control FSM with registered ready/active/error outputs.
    // GAP is entered with the counter loaded to GAP_CYCLES: the entry cycle is
    // the disconnect cycle, followed by GAP_CYCLES idle clocks before connect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cur       <= '0;
            tgt       <= '0;
            tgt_none  <= 1'b1;
            gap_cnt   <= '0;
            active    <= '0;
            sel_ready <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            // Clear first so a same-cycle rejection below wins.
            if (err_clr)
                sel_err <= 1'b0;

            case (state)
                S_IDLE, S_CONN: begin
                    sel_ready <= 1'b1;
                    if (accept) begin
                        if (bad_idx) begin
                            sel_err <= 1'b1;
                        end else if (!same_port) begin
                            tgt      <= sel_idx[PIDX_W-1:0];
                            tgt_none <= !sel_en;
                            if (state == S_CONN) begin
                                state     <= S_DRAIN;
                                active    <= '0;
                                sel_ready <= 1'b0;
                            end else if (sel_en) begin
                                state     <= S_GAP;
                                gap_cnt   <= GAP_LOAD;
                                sel_ready <= 1'b0;
                            end
                        end
                    end
                end

                S_DRAIN: begin
                    // Wait for the connected master to end its transfer.
                    if (ss_L_ports[cur]) begin
                        state   <= S_GAP;
                        gap_cnt <= GAP_LOAD;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == 8'd0) begin
                        cur       <= tgt;
                        sel_ready <= 1'b1;
                        if (tgt_none) begin
                            state  <= S_IDLE;
                            active <= '0;
                        end else begin
                            state  <= S_CONN;
                            active <= ONE << tgt;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    active    <= '0;
                    sel_ready <= 1'b0;
                end
            endcase
        end
    end

    // Bus routing: the selected port stays wired through DRAIN so the
    // transfer in flight completes; everything else sees idle levels.
    always_comb begin
        route      = (state == S_CONN) || (state == S_DRAIN);
        mosi       = 1'b0;
        sck        = SCK_IDLE;
        ss_L       = 1'b1;
        miso_ports = '0;
        if (route) begin
            mosi = mosi_ports[cur];
            sck  = sck_ports[cur];
            ss_L = ss_L_ports[cur];
            if (miso)
                miso_ports = ONE << cur;
        end
    end

endmodule

// File: tb/tb_spi_switch_arbiter.sv
// Directed bench for spi_switch_arbiter (PORTS=4, GAP_CYCLES=4, CPOL=0).
module tb_spi_switch_arbiter;

    logic       clk;
    logic       rst;
    logic       sel_valid;
    logic       sel_ready;
    logic       sel_en;
    logic [2:0] sel_idx;
    logic       sel_err;
    logic       err_clr;
    logic [3:0] active;
    logic       mosi;
    logic       sck;
    logic       ss_L;
    logic       miso;
    logic [3:0] mosi_ports;
    logic [3:0] sck_ports;
    logic [3:0] ss_L_ports;
    logic [3:0] miso_ports;

    int checks = 0;
    int errors = 0;

    spi_switch_arbiter #(.PORTS(4), .GAP_CYCLES(4), .CPOL(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .sel_en     (sel_en),
        .sel_idx    (sel_idx),
        .sel_err    (sel_err),
        .err_clr    (err_clr),
        .active     (active),
        .mosi       (mosi),
        .sck        (sck),
        .ss_L       (ss_L),
        .miso       (miso),
        .mosi_ports (mosi_ports),
        .sck_ports  (sck_ports),
        .ss_L_ports (ss_L_ports),
        .miso_ports (miso_ports)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; sel_valid = 1'b0; sel_en = 1'b0; sel_idx = 3'd0; err_clr = 1'b0;
        miso = 1'b1; mosi_ports = 4'hF; sck_ports = 4'hF; ss_L_ports = 4'h0;

        // Reset state before any clock edge
        #3;
        chk("rst_ss_L", ss_L, 1'b1);
        chk("rst_sck", sck, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_active", active, 4'b0000);
        chk("rst_ready", sel_ready, 1'b0);
        chk("rst_err", sel_err, 1'b0);
        chk("rst_miso_ports", miso_ports, 4'b0000);
        ss_L_ports = 4'hF; sck_ports = 4'h0; mosi_ports = 4'h0; miso = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("ready_before_edge", sel_ready, 1'b0);
        tick();
        chk("ready_after_release", sel_ready, 1'b1);

        // Disconnect request while idle stays idle
        sel_valid = 1'b1; sel_en = 1'b0; sel_idx = 3'd2;
        tick();
        sel_valid = 1'b0;
        chk("idle_off_ready", sel_ready, 1'b1);
        chk("idle_off_active", active, 4'b0000);

        // Connect port 2 from IDLE: active exactly 5 clocks after acceptance
        sel_valid = 1'b1; sel_en = 1'b1; sel_idx = 3'd2;
        tick();
        sel_valid = 1'b0;
        chk("gap_ready", sel_ready, 1'b0);
        // Unconnected inputs driven to busy levels must not leak during GAP
        ss_L_ports = 4'h0; sck_ports = 4'hF; mosi_ports = 4'hF; miso = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gap_active", active, 4'b0000);
        end
        chk("gap_ss_L", ss_L, 1'b1);
        chk("gap_sck", sck, 1'b0);
        chk("gap_mosi", mosi, 1'b0);
        chk("gap_miso_ports", miso_ports, 4'b0000);
        tick();
        chk("conn2_active", active, 4'b0100);
        chk("conn2_ready", sel_ready, 1'b1);
        chk("conn2_mosi_hi", mosi, 1'b1);
        chk("conn2_sck_hi", sck, 1'b1);
        chk("conn2_ss_L_lo", ss_L, 1'b0);
        chk("conn2_miso_ports", miso_ports, 4'b0100);
        ss_L_ports = 4'b1011; sck_ports = 4'b1011; mosi_ports = 4'b1011; miso = 1'b0;
        #1;
        chk("conn2_mosi_lo", mosi, 1'b0);
        chk("conn2_sck_lo", sck, 1'b0);
        chk("conn2_ss_L_hold", ss_L, 1'b0);
        chk("conn2_miso_zero", miso_ports, 4'b0000);

        // Switch to port 0 while port 2 is mid-transfer
        sel_valid = 1'b1; sel_en = 1'b1; sel_idx = 3'd0;
        tick();
        chk("drain_active", active, 4'b0000);
        chk("drain_ready", sel_ready, 1'b0);
        chk("drain_ss_L", ss_L, 1'b0);
        mosi_ports = 4'b0100;
        #1;
        chk("drain_mosi_routed", mosi, 1'b1);
        // Requests while draining are ignored
        sel_idx = 3'd3;
        tick();
        sel_idx = 3'd5;
        tick(); tick();
        sel_valid = 1'b0;
        chk("drain_no_err", sel_err, 1'b0);
        chk("drain_still_ss_L", ss_L, 1'b0);
        ss_L_ports = 4'b1111;
        #1;
        chk("drain_release_ss_L", ss_L, 1'b1);
        tick();
        // Now in GAP; port 0 pulls low but bus must stay idle
        ss_L_ports = 4'b1110; sck_ports = 4'hF;
        sel_valid = 1'b1; sel_en = 1'b1; sel_idx = 3'd5;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gap2_ss_L", ss_L, 1'b1);
            chk("gap2_sck", sck, 1'b0);
        end
        sel_valid = 1'b0;
        chk("gap2_no_err", sel_err, 1'b0);
        chk("gap2_active", active, 4'b0000);
        tick();
        chk("conn0_active", active, 4'b0001);
        chk("conn0_ss_L", ss_L, 1'b0);
        chk("conn0_sck", sck, 1'b1);

        // Out-of-range request and sticky error
        sel_valid = 1'b1; sel_en = 1'b1; sel_idx = 3'd5;
        tick();
        sel_valid = 1'b0;
        chk("bad_err", sel_err, 1'b1);
        chk("bad_active", active, 4'b0001);
        chk("bad_ready", sel_ready, 1'b1);
        sel_valid = 1'b1; sel_idx = 3'd6; err_clr = 1'b1;
        tick();
        sel_valid = 1'b0;
        chk("clr_vs_set", sel_err, 1'b1);
        tick();
        err_clr = 1'b0;
        chk("clr_err", sel_err, 1'b0);
        chk("clr_active", active, 4'b0001);

        // Move to port 1, re-request port 1, then disconnect
        ss_L_ports = 4'b1111;
        sel_valid = 1'b1; sel_en = 1'b1; sel_idx = 3'd1;
        tick();
        sel_valid = 1'b0;
        chk("to1_drain_ready", sel_ready, 1'b0);
        tick();
        repeat (4) tick();
        chk("to1_gap_active", active, 4'b0000);
        tick();
        chk("conn1_active", active, 4'b0010);
        sel_valid = 1'b1; sel_en = 1'b1; sel_idx = 3'd1;
        tick();
        sel_valid = 1'b0;
        chk("same_active", active, 4'b0010);
        chk("same_ready", sel_ready, 1'b1);
        sel_valid = 1'b1; sel_en = 1'b0;
        tick();
        sel_valid = 1'b0; sel_en = 1'b1;
        chk("off_drain_active", active, 4'b0000);
        chk("off_drain_ready", sel_ready, 1'b0);
        tick();
        repeat (4) tick();
        chk("off_gap_ready", sel_ready, 1'b0);
        tick();
        chk("off_idle_ready", sel_ready, 1'b1);
        chk("off_idle_active", active, 4'b0000);
        chk("off_idle_ss_L", ss_L, 1'b1);

        // Connect port 3, then reset asynchronously mid-transfer
        sel_valid = 1'b1; sel_en = 1'b1; sel_idx = 3'd3;
        tick();
        sel_valid = 1'b0;
        repeat (4) tick();
        tick();
        chk("conn3_active", active, 4'b1000);
        ss_L_ports = 4'b0111; miso = 1'b1;
        #1;
        chk("conn3_ss_L", ss_L, 1'b0);
        chk("conn3_miso_ports", miso_ports, 4'b1000);
        #2;
        rst = 1'b1;
        #1;
        chk("async_ss_L", ss_L, 1'b1);
        chk("async_active", active, 4'b0000);
        chk("async_ready", sel_ready, 1'b0);
        chk("async_miso_ports", miso_ports, 4'b0000);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", sel_ready, 1'b1);
        repeat (3) tick();
        chk("post_rst_active", active, 4'b0000);
        chk("post_rst_ss_L", ss_L, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
